// File: rtl/imem_fetch_sequencer.sv
// Sequences a single-port instruction memory: LOAD streams a program image in, FETCH reads words out sequentially.
// Latency: a fetch address issued in cycle n returns as instr_valid in cycle n+2; throughput is 1 word/cycle.
// Backpressure: ld_ready gates the loader; stall freezes the instr outputs and parks the one in-flight word.
//
// Ports:
//   clock, reset (async, active-low)
//   ld_valid/ld_data/ld_last/ld_ready   loader stream
//   start                               skip loading from IDLE
//   stall, redirect_valid/redirect_pc   downstream stall and branch redirect
//   mem_addr/mem_data_in/mem_rw/mem_en  memory request (combinational), mem_data_out read data (next cycle)
//   instr/instr_pc/instr_valid          fetched word to the instruction register stage
//   state, load_count, error            status (error is sticky until reset)
module imem_fetch_sequencer #(
  parameter logic [31:0] PC_BASE_ADDR = 32'h8002_0000,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          CNT_W        = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic             start,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data_in,
  output logic             mem_rw,
  output logic             mem_en,
  input  logic [31:0]      mem_data_out,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] load_count,
  output logic             error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH_WORDS);
  localparam logic [32:0]      FETCH_SPAN = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        hold_full;
  logic [31:0] hold_dat;
  logic [31:0] hold_pc;

  // 33-bit subtract: bit 32 is the borrow, set when pc lies below the base.
  logic [32:0] fetch_off;
  logic        fetch_in_range;
  logic        fetch_try;
  logic        issue;
  logic        fetch_oob;
  logic        load_room;

  assign fetch_off      = {1'b0, pc} - {1'b0, PC_BASE_ADDR};
  assign fetch_in_range = !fetch_off[32] && (fetch_off < FETCH_SPAN);
  // A fetch is attempted only when neither stall nor redirect holds it off;
  // range is judged at that moment so a stalled pc past the end is harmless.
  assign fetch_try      = (state == S_FETCH) && !stall && !redirect_valid;
  assign issue          = fetch_try && fetch_in_range;
  assign fetch_oob      = fetch_try && !fetch_in_range;
  assign load_room      = (load_count < DEPTH_CNT);

  always_comb begin
    ld_ready    = 1'b0;
    mem_en      = 1'b0;
    mem_rw      = 1'b1;
    mem_addr    = 32'd0;
    mem_data_in = 32'd0;
    case (state)
      S_LOAD: begin
        ld_ready = load_room;
        mem_addr = 32'({load_count, 2'b00});
        if (ld_valid && load_room) begin
          mem_en      = 1'b1;
          mem_rw      = 1'b0;
          mem_data_in = ld_data;
        end
      end
      S_FETCH: begin
        mem_addr = fetch_off[31:0];
        mem_en   = issue;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= PC_BASE_ADDR;
      load_count  <= '0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      error       <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= 32'd0;
      hold_full   <= 1'b0;
      hold_dat    <= 32'd0;
      hold_pc     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_valid) begin
            state <= S_LOAD;
          end else if (start) begin
            state <= S_FETCH;
            pc    <= PC_BASE_ADDR;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            if (load_room) begin
              load_count <= load_count + CNT_W'(1);
              if (ld_last) begin
                state <= S_FETCH;
                pc    <= PC_BASE_ADDR;
              end
            end else begin
              // Image larger than the memory: stop rather than wrap.
              error <= 1'b1;
              state <= S_HALT;
            end
          end
        end
        S_FETCH: begin
          if (redirect_valid) begin
            // Squash everything in the pipe, including a parked word.
            pc          <= redirect_pc & 32'hFFFF_FFFC;
            inflight    <= 1'b0;
            hold_full   <= 1'b0;
            instr_valid <= 1'b0;
          end else begin
            if (issue) begin
              pc          <= pc + 32'd4;
              inflight    <= 1'b1;
              inflight_pc <= pc;
            end else begin
              inflight <= 1'b0;
            end
            if (fetch_oob) begin
              error <= 1'b1;
              state <= S_HALT;
            end
            if (!stall) begin
              // The parked word is older than anything in flight, so it drains first.
              if (hold_full) begin
                instr     <= hold_dat;
                instr_pc  <= hold_pc;
                hold_full <= 1'b0;
              end else if (inflight) begin
                instr    <= mem_data_out;
                instr_pc <= inflight_pc;
              end
              instr_valid <= hold_full | inflight;
            end else if (inflight) begin
              // Read data is only valid for one cycle; park it until the stall lifts.
              hold_dat  <= mem_data_out;
              hold_pc   <= inflight_pc;
              hold_full <= 1'b1;
            end
          end
        end
        default: begin
          instr_valid <= 1'b0;
          inflight    <= 1'b0;
          hold_full   <= 1'b0;
        end
      endcase
    end
  end

endmodule
